// File: rtl/mux_seq_pkg.sv
// Shared mode encodings, dwell counter width and the index-width helper
// used across the mux_seq slice.
package mux_seq_pkg;

  typedef enum logic [1:0] {
    MANUAL    = 2'b00,
    SCAN_UP   = 2'b01,
    SCAN_DOWN = 2'b10,
    HOLD      = 2'b11
  } mode_e;

  localparam int DWELL_W = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/mux_seq_if.sv
// Control/data bundle for mux_seq: the driver uses master, the mux uses slave.
interface mux_seq_if
  import mux_seq_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CH    = 16
);

  localparam int SELW = clog2(CH);

  logic [CH*WIDTH-1:0] d;
  logic [SELW-1:0]     s;
  logic [1:0]          mode;
  logic                en;
  logic [DWELL_W-1:0]  dwell;
  logic [WIDTH-1:0]    y;
  logic [SELW-1:0]     ch;
  logic                valid;
  logic                wrap;
  logic                err;

  modport master (
    output d, s, mode, en, dwell,
    input  y, ch, valid, wrap, err
  );

  modport slave (
    input  d, s, mode, en, dwell,
    output y, ch, valid, wrap, err
  );

endinterface

// File: rtl/mux_seq_ctr.sv
// Channel sequencer: dwell counter plus up/down channel index with wrap
// detection and out-of-range manual select flagging.
module mux_seq_ctr
  import mux_seq_pkg::*;
#(
  parameter int CH   = 16,
  parameter int SELW = clog2(CH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               primed,
  input  logic [1:0]         mode,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [SELW-1:0]    s,
  output logic [SELW-1:0]    ch_next,
  output logic               load,
  output logic [SELW-1:0]    ch,
  output logic               wrap,
  output logic               err
);

  localparam logic [SELW:0]   CH_L   = (SELW + 1)'(CH);
  localparam logic [SELW-1:0] CH_MAX = SELW'(CH - 1);

  logic [SELW-1:0]    ch_reg, ch_nx;
  logic [DWELL_W-1:0] cnt_reg, cnt_nx;
  logic [1:0]         mode_reg, mode_nx;
  logic [SELW-1:0]    s_reg, s_nx;
  logic               wrap_reg, wrap_nx;
  logic               err_reg, err_nx;
  logic               s_bad;
  logic               mode_chg;
  logic [DWELL_W-1:0] cnt_eff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_reg   <= '0;
      cnt_reg  <= '0;
      mode_reg <= MANUAL;
      s_reg    <= '0;
      wrap_reg <= 1'b0;
      err_reg  <= 1'b0;
    end else begin
      ch_reg   <= ch_nx;
      cnt_reg  <= cnt_nx;
      mode_reg <= mode_nx;
      s_reg    <= s_nx;
      wrap_reg <= wrap_nx;
      err_reg  <= err_nx;
    end
  end

  // A mode change restarts the dwell count from zero in the same cycle;
  // the first enabled cycle after reset only loads, so scans start on ch 0.
  always_comb begin
    s_bad    = ({1'b0, s} >= CH_L);
    mode_chg = (mode != mode_reg);
    cnt_eff  = mode_chg ? '0 : cnt_reg;
    ch_nx    = ch_reg;
    cnt_nx   = cnt_reg;
    mode_nx  = mode_reg;
    s_nx     = s_reg;
    wrap_nx  = 1'b0;
    err_nx   = 1'b0;
    load     = 1'b0;
    if (en) begin
      mode_nx = mode;
      s_nx    = s;
      load    = 1'b1;
      case (mode)
        MANUAL: begin
          cnt_nx = '0;
          if (s_bad) begin
            load   = 1'b0;
            // Flag only a newly presented bad select, not a held one.
            err_nx = !primed || mode_chg || (s != s_reg);
          end else begin
            ch_nx = s;
          end
        end
        SCAN_UP, SCAN_DOWN: begin
          if (!primed) begin
            cnt_nx = '0;
          end else if (cnt_eff >= dwell) begin
            cnt_nx = '0;
            if (mode == SCAN_UP) begin
              wrap_nx = (ch_reg == CH_MAX);
              ch_nx   = wrap_nx ? '0 : ch_reg + 1'b1;
            end else begin
              wrap_nx = (ch_reg == '0);
              ch_nx   = wrap_nx ? CH_MAX : ch_reg - 1'b1;
            end
          end else begin
            cnt_nx = cnt_eff + 1'b1;
          end
        end
        default: cnt_nx = cnt_eff;
      endcase
    end
    ch_next = ch_nx;
  end

  assign ch   = ch_reg;
  assign wrap = wrap_reg;
  assign err  = err_reg;

endmodule

// File: rtl/mux_seq.sv
// Sequenced channel multiplexer: registered output of the channel chosen by
// the sequencer, manually or by up/down scanning with a programmable dwell.
module mux_seq
  import mux_seq_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CH    = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  mux_seq_if.slave bus
);

  localparam int SELW = clog2(CH);

  logic [WIDTH-1:0] chan [CH];
  logic [SELW-1:0]  ch_next;
  logic             load;
  logic [WIDTH-1:0] y_reg;
  logic             valid_reg;

  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_chan
      assign chan[gi] = bus.d[gi*WIDTH +: WIDTH];
    end
  endgenerate

  mux_seq_ctr #(
    .CH   (CH),
    .SELW (SELW)
  ) u_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (bus.en),
    .primed  (valid_reg),
    .mode    (bus.mode),
    .dwell   (bus.dwell),
    .s       (bus.s),
    .ch_next (ch_next),
    .load    (load),
    .ch      (bus.ch),
    .wrap    (bus.wrap),
    .err     (bus.err)
  );

  // A rejected manual select keeps the previous sample in y.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_reg     <= '0;
      valid_reg <= 1'b0;
    end else if (bus.en) begin
      valid_reg <= 1'b1;
      if (load) y_reg <= chan[ch_next];
    end
  end

  assign bus.y     = y_reg;
  assign bus.valid = valid_reg;

endmodule

// File: tb/tb_mux_seq.sv
// Directed bench for mux_seq: a 16x1 instance and a 10x4 instance exercising
// manual select, up/down scan, hold, enable freeze and async reset.
module tb_mux_seq;
  import mux_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mux_seq_if #(.WIDTH(1), .CH(16)) b16 ();
  mux_seq_if #(.WIDTH(4), .CH(10)) b10 ();

  mux_seq #(.WIDTH(1), .CH(16)) u16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b16.slave)
  );

  mux_seq #(.WIDTH(4), .CH(10)) u10 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b10.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    $display("t=%0t %s obs=%0h exp=%0h", $time, tag, obs, exp);
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b1;
    b16.d     = 16'hAAAA;
    b16.s     = '0;
    b16.mode  = MANUAL;
    b16.en    = 1'b0;
    b16.dwell = '0;
    b10.d     = '0;
    b10.s     = '0;
    b10.mode  = MANUAL;
    b10.en    = 1'b0;
    b10.dwell = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_y", b16.y, 0);
    chk("rst_ch", b16.ch, 0);
    chk("rst_valid", b16.valid, 0);
    chk("rst_wrap", b16.wrap, 0);
    chk("rst_err", b16.err, 0);

    // Manual stepping over all 16 channels of 0xAAAA
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    b16.en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      b16.s = 4'(i);
      chk($sformatf("man_pre%0d", i), b16.y, (i == 0) ? 0 : ((i - 1) & 1));
      step(1);
      chk($sformatf("man_y%0d", i), b16.y, i & 1);
      chk($sformatf("man_ch%0d", i), b16.ch, i);
      step(9);
    end
    chk("man_valid", b16.valid, 1);

    // Scan up from ch 15, dwell 2: wrap to 0 on the third edge
    b16.mode  = SCAN_UP;
    b16.dwell = 8'd2;
    step(1);
    chk("up_ch_e1", b16.ch, 15);
    chk("up_y_e1", b16.y, 1);
    chk("up_wrap_e1", b16.wrap, 0);
    step(1);
    chk("up_ch_e2", b16.ch, 15);
    step(1);
    chk("up_ch_e3", b16.ch, 0);
    chk("up_wrap_e3", b16.wrap, 1);
    chk("up_y_e3", b16.y, 0);
    step(1);
    chk("up_wrap_e4", b16.wrap, 0);
    chk("up_ch_e4", b16.ch, 0);
    step(1);
    chk("up_ch_e5", b16.ch, 0);
    step(1);
    chk("up_ch_e6", b16.ch, 1);
    chk("up_y_e6", b16.y, 1);

    // Freeze mid-count for 5 cycles, then resume at the same count
    step(1);
    b16.en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk($sformatf("frz_ch%0d", i), b16.ch, 1);
      chk($sformatf("frz_y%0d", i), b16.y, 1);
      chk($sformatf("frz_wrap%0d", i), b16.wrap, 0);
    end
    b16.en = 1'b1;
    step(1);
    chk("res_ch_a", b16.ch, 1);
    step(1);
    chk("res_ch_b", b16.ch, 2);
    chk("res_y_b", b16.y, 0);

    // Hold: index frozen, data still resampled
    b16.mode = HOLD;
    step(2);
    chk("hold_ch", b16.ch, 2);
    chk("hold_y", b16.y, 0);
    b16.d = 16'h5555;
    step(1);
    chk("hold_y_new", b16.y, 1);
    chk("hold_ch_new", b16.ch, 2);
    b16.d = 16'hAAAA;

    // Scan to ch 7 with dwell 0, then async reset between edges
    b16.mode  = SCAN_UP;
    b16.dwell = 8'd0;
    step(5);
    chk("d0_ch7", b16.ch, 7);
    chk("d0_y7", b16.y, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_y", b16.y, 0);
    chk("arst_ch", b16.ch, 0);
    chk("arst_valid", b16.valid, 0);
    chk("arst_wrap", b16.wrap, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1);
    chk("rel_ch", b16.ch, 0);
    chk("rel_valid", b16.valid, 1);
    chk("rel_wrap", b16.wrap, 0);
    step(1);
    chk("rel_ch_next", b16.ch, 1);
    chk("rel_y_next", b16.y, 1);

    // Dwell shortened below the running count: advance on the next edge
    b16.dwell = 8'd5;
    step(3);
    chk("dw5_ch", b16.ch, 1);
    b16.dwell = 8'd1;
    step(1);
    chk("dw1_ch_a", b16.ch, 2);
    step(1);
    chk("dw1_ch_b", b16.ch, 2);
    step(1);
    chk("dw1_ch_c", b16.ch, 3);
    b16.en = 1'b0;

    // CH=10, channel k carries k+1; scan down with dwell 0
    for (int k = 0; k < 10; k++) b10.d[k*4 +: 4] = 4'(k + 1);
    b10.mode  = SCAN_DOWN;
    b10.dwell = 8'd0;
    chk("c10_valid0", b10.valid, 0);
    b10.en = 1'b1;
    step(1);
    chk("dn_ch0", b10.ch, 0);
    chk("dn_y0", b10.y, 1);
    chk("dn_valid", b10.valid, 1);
    chk("dn_wrap0", b10.wrap, 0);
    step(1);
    chk("dn_ch9", b10.ch, 9);
    chk("dn_y9", b10.y, 4'hA);
    chk("dn_wrap9", b10.wrap, 1);
    step(1);
    chk("dn_ch8", b10.ch, 8);
    chk("dn_y8", b10.y, 4'h9);
    chk("dn_wrap8", b10.wrap, 0);

    // Out-of-range manual selects on non-power-of-two CH
    b10.mode = MANUAL;
    b10.s    = 4'd3;
    step(1);
    chk("m10_ch3", b10.ch, 3);
    chk("m10_y3", b10.y, 4);
    chk("m10_err3", b10.err, 0);
    b10.s = 4'd12;
    step(1);
    chk("oor12_ch", b10.ch, 3);
    chk("oor12_y", b10.y, 4);
    chk("oor12_err", b10.err, 1);
    step(1);
    chk("oor12_err2", b10.err, 0);
    chk("oor12_ch2", b10.ch, 3);
    b10.s = 4'd10;
    step(1);
    chk("oor10_err", b10.err, 1);
    chk("oor10_ch", b10.ch, 3);
    b10.s = 4'd9;
    step(1);
    chk("m10_ch9", b10.ch, 9);
    chk("m10_y9", b10.y, 4'hA);
    chk("m10_err9", b10.err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_seq.md
MUX_SEQ -- requirements
Module: mux_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 1: bits per data channel, >=1.
REQ-002 SHALL have parameter CH, default 16: channel count, 2..256, power of two not required.
REQ-003 SHALL have localparam SELW = clog2(CH): select/channel index width.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-006 SHALL have port d  input  CH*WIDTH: packed channels; channel k = d[k*WIDTH +: WIDTH].
REQ-007 SHALL have port s  input  SELW: manual channel select.
REQ-008 SHALL have port mode  input  2: 00 MANUAL, 01 SCAN_UP, 10 SCAN_DOWN, 11 HOLD.
REQ-009 SHALL have port en  input  1: global enable; low freezes all state.
REQ-010 SHALL have port dwell  input  8: cycles per channel in scan modes, minus one.
REQ-011 SHALL have port y  output  WIDTH: registered selected channel data.
REQ-012 SHALL have port ch  output  SELW: index of channel currently driving y.
REQ-013 SHALL have port valid  output  1: y holds a sample taken with en high.
REQ-014 SHALL have port wrap  output  1: one-cycle pulse on scan wrap-around.
REQ-015 SHALL have port err  output  1: one-cycle pulse on out-of-range manual select.

Function
REQ-016 SHALL register y: y(t+1) = channel ch_next(t) of d(t); latency one cycle from select/d change to y.
REQ-017 MANUAL: ch_next = s when s < CH; if s >= CH, ch and y hold and err pulses for that cycle.
REQ-018 SCAN_UP: dwell counter counts 0..dwell; on reaching dwell, counter clears and ch advances +1; ch = CH-1 advances to 0 and wrap pulses.
REQ-019 SCAN_DOWN: as REQ-018, ch decrements; ch = 0 advances to CH-1 and wrap pulses.
REQ-020 dwell = 0 SHALL advance ch every enabled cycle.
REQ-021 HOLD: ch and dwell counter frozen; y keeps resampling d at ch.
REQ-022 Any mode change SHALL clear the dwell counter; scan starts from current ch, first advance after dwell+1 cycles.
REQ-023 dwell change mid-count SHALL take effect at next compare; counter already > new dwell SHALL advance on next cycle.
REQ-024 en low SHALL freeze ch, dwell counter, y, valid; wrap and err forced 0.
REQ-025 valid SHALL set on first enabled cycle after reset and stay set until reset.
REQ-026 wrap and err SHALL never be high two consecutive cycles without a fresh triggering event.

Reset
REQ-027 rst_n low SHALL immediately force y=0, ch=0, dwell counter=0, valid=0, wrap=0, err=0.
REQ-028 Release SHALL take effect on the next rising clk; first enabled edge samples channel 0 (SCAN) or s (MANUAL).
REQ-029 Reset asserted mid-scan SHALL abort the dwell count; no wrap pulse generated.

Structure
REQ-030 Package mux_seq_pkg SHALL hold the mode encodings (MANUAL, SCAN_UP, SCAN_DOWN, HOLD) and the clog2 function.
REQ-031 Sub-module mux_seq_ctr SHALL implement dwell counter plus up/down channel index with wrap detection; data path stays in mux_seq.
REQ-032 Out-of-range handling SHALL be correct for non-power-of-two CH (e.g. CH=10).

Verification
REQ-033 CH=16, WIDTH=1, d=16'hAAAA, MANUAL, s stepped 0..15 every 10 cycles -> y=0,1,0,1,... one cycle after each s change, ch=s.
REQ-034 SCAN_UP, dwell=2, CH=16 -> ch advances every 3 cycles, 15 -> 0 with wrap high exactly one cycle.
REQ-035 SCAN_DOWN, dwell=0, CH=10 -> ch 0 -> 9 -> 8 each cycle, wrap on 0 -> 9 transition.
REQ-036 CH=10, MANUAL, s=12 after s=3 -> ch stays 3, y unchanged, err one-cycle pulse.
REQ-037 en low 5 cycles mid-scan -> ch, y, counter frozen, wrap=0; scan resumes at same count on en high.
REQ-038 rst_n low mid-cycle during SCAN_UP at ch=7 -> y=0, ch=0, valid=0 immediately without clk edge.
